// File: rtl/calc_pkg.sv
// Shared opcodes, FSM encoding and elaboration-time helpers for the calculator ALU.
package calc_pkg;

   localparam logic [3:0] OP_ADD = 4'b1101;
   localparam logic [3:0] OP_SUB = 4'b1110;
   localparam logic [3:0] OP_MUL = 4'b1100;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Largest value representable with n decimal digits.
   function automatic int max_dec(input int n);
      int v;
      v = 1;
      for (int i = 0; i < n; i++) v = v * 10;
      return v - 1;
   endfunction

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Unsigned shift-add multiplier: one multiplier bit per cycle, LSB first, fixed WIDTH cycles.
module seq_shift_add_mul
   import calc_pkg::*;
#(
   parameter int WIDTH = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [CW-1:0]      cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         cnt     <= '0;
      end else begin
         done <= 1'b0;
         if (!busy) begin
            if (start) begin
               busy    <= 1'b1;
               product <= '0;
               mcand   <= {{WIDTH{1'b0}}, a};
               mplier  <= b;
               cnt     <= '0;
            end
         end else begin
            // No early exit: latency stays fixed regardless of operand values.
            if (mplier[0]) product <= product + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_seq_calc.sv
// Multi-cycle decimal-bounded ALU (add/sub/mul) with start/busy/done handshake.
module alu_seq_calc
   import calc_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int WIDTH    = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [3:0]        op_val,
   input  logic [WIDTH-1:0]  op1,
   input  logic [WIDTH-1:0]  op2,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              f_OF,
   output logic              f_sig_res,
   output logic              f_err
);

   localparam int                 MAX_DEC = max_dec(N_DIGITS);
   localparam logic [2*WIDTH-1:0] MAX_W   = (2*WIDTH)'(MAX_DEC);

   logic [1:0]         state;
   logic [3:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               err_q, cnt_q;
   logic               in_err, calc_fin;
   logic               mul_start, mul_busy, mul_done;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   res_n;
   logic               of_n, sg_n;

   assign in_err = !(op_val == OP_ADD || op_val == OP_SUB || op_val == OP_MUL)
                   || ((2*WIDTH)'(op1) > MAX_W) || ((2*WIDTH)'(op2) > MAX_W);

   assign mul_start = (state == S_IDLE) && start && (op_val == OP_MUL) && !in_err && !mul_busy;
   assign sum       = {1'b0, a_q} + {1'b0, b_q};
   assign busy      = (state == S_CALC);
   assign done      = (state == S_DONE);

   seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (op1),
      .b       (op2),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (product)
   );

   // Non-MUL work spends two cycles in CALC so ADD/SUB/error land at start+2.
   always_comb begin
      calc_fin = (err_q || op_q != OP_MUL) ? cnt_q : mul_done;
   end

   always_comb begin
      res_n = '0;
      of_n  = 1'b0;
      sg_n  = 1'b0;
      if (!err_q) begin
         case (op_q)
            OP_ADD: if ((2*WIDTH)'(sum) > MAX_W) of_n = 1'b1;
                    else res_n = sum[WIDTH-1:0];
            OP_SUB: if (a_q >= b_q) res_n = a_q - b_q;
                    else begin
                       res_n = b_q - a_q;
                       sg_n  = 1'b1;
                    end
            OP_MUL: if (product > MAX_W) of_n = 1'b1;
                    else res_n = product[WIDTH-1:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         err_q     <= 1'b0;
         cnt_q     <= 1'b0;
         result    <= '0;
         f_OF      <= 1'b0;
         f_sig_res <= 1'b0;
         f_err     <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) begin
               op_q  <= op_val;
               a_q   <= op1;
               b_q   <= op2;
               err_q <= in_err;
               cnt_q <= 1'b0;
               state <= S_CALC;
            end
            S_CALC: if (calc_fin) begin
               result    <= res_n;
               f_OF      <= of_n;
               f_sig_res <= sg_n;
               f_err     <= err_q;
               state     <= S_DONE;
            end else begin
               cnt_q <= 1'b1;
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_calc.sv
// Randomized and directed checks of alu_seq_calc against an arithmetic reference model.
module tb_alu_seq_calc;
   import calc_pkg::*;

   localparam int W    = 14;
   localparam int MAXD = 9999;

   logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
   logic [3:0]    op_val = '0;
   logic [W-1:0]  op1 = '0, op2 = '0;
   logic          busy, done, f_OF, f_sig_res, f_err;
   logic [W-1:0]  result;

   int checks = 0, errors = 0;

   alu_seq_calc #(.N_DIGITS(4), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_val(op_val), .op1(op1), .op2(op2),
      .busy(busy), .done(done), .result(result), .f_OF(f_OF), .f_sig_res(f_sig_res),
      .f_err(f_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Plain-arithmetic reference: value, flags {of,sg,er}, and edges from start to done.
   task automatic model(input logic [3:0] op, input int a, input int b,
                        output int res, output logic [2:0] fl, output int lat);
      logic of, sg, er;
      res = 0; of = 0; sg = 0; er = 0;
      if (!(op == OP_ADD || op == OP_SUB || op == OP_MUL) || a > MAXD || b > MAXD) er = 1;
      else if (op == OP_ADD) begin
         if (a + b > MAXD) of = 1; else res = a + b;
      end else if (op == OP_SUB) begin
         if (b > a) begin sg = 1; res = b - a; end else res = a - b;
      end else begin
         if (a * b > MAXD) of = 1; else res = a * b;
      end
      fl  = {of, sg, er};
      lat = (op == OP_MUL && !er) ? W + 1 : 2;
   endtask

   // Issues one op from an IDLE negedge, scrambles inputs while busy, returns observations.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit hold, output int lat, output logic [W-1:0] r,
                         output logic [2:0] fl, output logic done_after, output bit busy_ok);
      op_val = op; op1 = a; op2 = b; start = 1'b1;
      @(negedge clk);
      lat = 0; busy_ok = 1;
      if (!hold) start = 1'b0;
      while (done !== 1'b1 && lat < 100) begin
         if (busy !== 1'b1) busy_ok = 0;
         op_val = 4'($urandom); op1 = W'($urandom); op2 = W'($urandom);
         @(negedge clk);
         lat++;
      end
      if (busy !== 1'b0) busy_ok = 0;
      r  = result;
      fl = {f_OF, f_sig_res, f_err};
      if (!hold) start = 1'b0;
      @(negedge clk);
      done_after = done;
      start = 1'b0;
   endtask

   task automatic test_reset;
      bit seen;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, result, f_OF, f_sig_res, f_err} !== '0)
         $display("FAIL reset_state got %0h exp 0", {busy, done, result, f_OF, f_sig_res, f_err});
      rst_n = 1'b1;
      @(negedge clk);
      op_val = OP_MUL; op1 = 99; op2 = 101; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, result, f_OF, f_sig_res, f_err} !== '0) begin
         errors++;
         $display("FAIL reset_mid_mul got %0h exp 0", {busy, done, result, f_OF, f_sig_res, f_err});
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0) seen = 1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_no_done got activity=1 exp 0");
      end
   endtask

   task automatic test_add;
      int av[2], bv[2], rv[2], lat;
      logic [2:0] fv[2], fl;
      logic [W-1:0] r;
      logic da;
      bit bok;
      av = '{4321, 9999}; bv = '{1234, 1}; rv = '{5555, 0}; fv = '{3'b000, 3'b100};
      for (int i = 0; i < 2; i++) begin
         run_op(OP_ADD, W'(av[i]), W'(bv[i]), 0, lat, r, fl, da, bok);
         checks++;
         if ({r, fl} !== {W'(rv[i]), fv[i]}) begin
            errors++;
            $display("FAIL add_%0d got r=%0d fl=%b exp r=%0d fl=%b", i, r, fl, rv[i], fv[i]);
         end
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL add_latency_%0d got %0d exp 2", i, lat);
         end
         checks++;
         if (da !== 1'b0 || !bok) begin
            errors++;
            $display("FAIL add_handshake_%0d got done_after=%b busy_ok=%0d exp 0/1", i, da, bok);
         end
      end
   endtask

   task automatic test_sub;
      int av[2], bv[2], rv[2], lat;
      logic [2:0] fv[2], fl;
      logic [W-1:0] r;
      logic da;
      bit bok;
      av = '{100, 777}; bv = '{250, 777}; rv = '{150, 0}; fv = '{3'b010, 3'b000};
      for (int i = 0; i < 2; i++) begin
         run_op(OP_SUB, W'(av[i]), W'(bv[i]), 0, lat, r, fl, da, bok);
         checks++;
         if ({r, fl} !== {W'(rv[i]), fv[i]}) begin
            errors++;
            $display("FAIL sub_%0d got r=%0d fl=%b exp r=%0d fl=%b", i, r, fl, rv[i], fv[i]);
         end
         checks++;
         if (lat !== 2 || da !== 1'b0 || !bok) begin
            errors++;
            $display("FAIL sub_timing_%0d got lat=%0d done_after=%b exp 2/0", i, lat, da);
         end
      end
   endtask

   task automatic test_mul;
      int av[2], bv[2], rv[2], lat;
      logic [2:0] fv[2], fl;
      logic [W-1:0] r;
      logic da;
      bit bok;
      av = '{99, 100}; bv = '{101, 100}; rv = '{9999, 0}; fv = '{3'b000, 3'b100};
      for (int i = 0; i < 2; i++) begin
         run_op(OP_MUL, W'(av[i]), W'(bv[i]), 0, lat, r, fl, da, bok);
         checks++;
         if ({r, fl} !== {W'(rv[i]), fv[i]}) begin
            errors++;
            $display("FAIL mul_%0d got r=%0d fl=%b exp r=%0d fl=%b", i, r, fl, rv[i], fv[i]);
         end
         checks++;
         if (lat !== W + 1 || da !== 1'b0 || !bok) begin
            errors++;
            $display("FAIL mul_timing_%0d got lat=%0d done_after=%b exp %0d/0", i, lat, da, W + 1);
         end
      end
   endtask

   task automatic test_errors;
      logic [3:0] ov[3];
      int av[3], bv[3], lat;
      logic [2:0] fl;
      logic [W-1:0] r;
      logic da;
      bit bok;
      ov = '{4'b0000, OP_ADD, OP_MUL}; av = '{5, 10000, 0}; bv = '{6, 1, 12000};
      for (int i = 0; i < 3; i++) begin
         run_op(ov[i], W'(av[i]), W'(bv[i]), 0, lat, r, fl, da, bok);
         checks++;
         if ({r, fl} !== {W'(0), 3'b001}) begin
            errors++;
            $display("FAIL err_%0d got r=%0d fl=%b exp r=0 fl=001", i, r, fl);
         end
         checks++;
         if (lat !== 2) begin
            errors++;
            $display("FAIL err_latency_%0d got %0d exp 2", i, lat);
         end
      end
   endtask

   task automatic test_handshake;
      int lat;
      logic [2:0] fl;
      logic [W-1:0] r;
      logic da;
      bit bok, extra;
      run_op(OP_MUL, W'(99), W'(101), 1, lat, r, fl, da, bok);
      checks++;
      if ({r, fl} !== {W'(9999), 3'b000} || lat !== W + 1) begin
         errors++;
         $display("FAIL hold_mul got r=%0d fl=%b lat=%0d exp r=9999 fl=000 lat=%0d", r, fl, lat, W + 1);
      end
      extra = 0;
      repeat (4) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0 || result !== W'(9999)) extra = 1;
      end
      checks++;
      if (extra || da !== 1'b0) begin
         errors++;
         $display("FAIL hold_single_op got extra=%0d done_after=%b exp 0/0", extra, da);
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] ov[3];
      int av[3], bv[3], lat, er, el;
      logic [2:0] fl, ef;
      logic [W-1:0] r;
      logic da;
      bit bok;
      ov = '{OP_SUB, OP_MUL, OP_ADD}; av = '{5, 37, 9998}; bv = '{9, 41, 1};
      for (int i = 0; i < 3; i++) begin
         run_op(ov[i], W'(av[i]), W'(bv[i]), 0, lat, r, fl, da, bok);
         model(ov[i], av[i], bv[i], er, ef, el);
         checks++;
         if ({r, fl} !== {W'(er), ef} || lat !== el) begin
            errors++;
            $display("FAIL b2b_%0d got r=%0d fl=%b lat=%0d exp r=%0d fl=%b lat=%0d",
                     i, r, fl, lat, er, ef, el);
         end
      end
   endtask

   task automatic test_random;
      logic [3:0] ops[4];
      logic [3:0] op;
      int a, b, lat, er, el;
      logic [2:0] fl, ef;
      logic [W-1:0] r;
      logic da;
      bit bok;
      ops = '{OP_ADD, OP_SUB, OP_MUL, 4'b0000};
      for (int i = 0; i < 40; i++) begin
         op = ops[$urandom_range(0, 3)];
         if (op == 4'b0000) op = 4'($urandom);
         if (op == OP_MUL && $urandom_range(0, 1) == 1) begin
            a = $urandom_range(0, 150); b = $urandom_range(0, 150);
         end else begin
            a = $urandom_range(0, 10300); b = $urandom_range(0, 10300);
         end
         run_op(op, W'(a), W'(b), 0, lat, r, fl, da, bok);
         model(op, a, b, er, ef, el);
         checks++;
         if ({r, fl} !== {W'(er), ef} || lat !== el || da !== 1'b0 || !bok) begin
            errors++;
            $display("FAIL rand_%0d op=%b a=%0d b=%0d got r=%0d fl=%b lat=%0d exp r=%0d fl=%b lat=%0d",
                     i, op, a, b, r, fl, lat, er, ef, el);
         end
      end
   endtask

   initial begin
      test_reset;
      test_add;
      test_sub;
      test_mul;
      test_errors;
      test_handshake;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
